command_encoder: RTL and testbench
==================================

// Module: command_encoder
// PURPOSE
//  Frames high-level engine commands into the byte stream consumed by control_unit (in_byte/in_ready/next).
//  Sits between an on-chip command source (boot config ROM walker, test host model) and control_unit's byte input.
//  Emits one opcode byte, then the opcode's operand fields MSB-first, exactly as control_unit parses them.
// PARAMETERS
//  n_blocks    256  block count; block field = $clog2(n_blocks) bits, sent as 1 byte, zero-extended
//  data_width  16   data field width (data_width/8 bytes); delay field = 2*data_width (fixed 4 bytes)
//  (instr width = `BLOCK_INSTR_WIDTH, reg addr width = `BLOCK_REG_ADDR_WIDTH, from core.vh/instr_dec.vh)
// PORTS
//  clk        in   1                      system clock
//  reset      in   1                      asynchronous, active-high
//  cmd_valid  in   1                      command request present
//  cmd_ready  out  1                      encoder can accept a command
//  cmd_opcode in   8                      `COMMAND_* code (controller.vh)
//  cmd_block  in   $clog2(n_blocks)       block target
//  cmd_reg    in   `BLOCK_REG_ADDR_WIDTH  register target
//  cmd_data   in   data_width             data operand
//  cmd_instr  in   `BLOCK_INSTR_WIDTH     block instruction
//  cmd_delay  in   2*data_width           buffer initial delay
//  out_byte   out  8                      stream byte to control_unit in_byte
//  out_valid  out  1                      drives control_unit in_ready
//  next       in   1                      consumer took out_byte (one-cycle pulse)
//  cmd_error  out  1                      one-cycle pulse: unknown opcode rejected
//  busy       out  1                      frame in progress
//  frames_sent out 16                     completed frames, wraps at 0xFFFF->0
// BEHAVIOUR
//  Reset (async): state IDLE; cmd_ready=1; out_valid=0; out_byte=0; cmd_error=0; busy=0; frames_sent=0. A partial frame is discarded, not resumed.
//  Accept: cmd_valid&&cmd_ready in IDLE latches all cmd_* fields. Cycle N+1: out_valid=1, out_byte=opcode, busy=1, cmd_ready=0.
//  Field map (in order): WRITE_BLOCK_INSTR: block, instr | WRITE_BLOCK_REG, UPDATE_BLOCK_REG: block, reg, data |
//    ALLOC_DELAY: data, delay | SET_INPUT_GAIN, SET_OUTPUT_GAIN: data | COMMIT_REG_UPDATES, SWAP_PIPELINES, RESET_PIPELINE: none.
//  Unknown opcode: accepted, cmd_error=1 at N+1, nothing emitted, returns to IDLE (cmd_ready=1 at N+1).
//  States: IDLE -> OPCODE -> [BLOCK] -> [REG] -> [DATA] -> [INSTR] -> [DELAY] -> IDLE; absent fields skipped.
//  Byte handshake: out_byte stable while out_valid && !next. On next: advance one byte, new byte valid next cycle.
//  Multi-byte fields MSB first; byte_ctr counts 0..nbytes-1 per field, reset on field change.
//  Last byte + next: out_valid=0, busy=0, cmd_ready=1, frames_sent+=1 next cycle; new command accepted no earlier than that cycle.
//  next while !out_valid: ignored. cmd_valid while busy: held off by cmd_ready=0 (no latch).
//  reg byte = zero-extended cmd_reg; block byte = zero-extended cmd_block.
// CONFIGURATION
//  CMD_ENC_BYTE_GAP_EN defined: after each next, out_valid drops for exactly 1 cycle before the following byte
//    (byte rate <= 1 per 2 cycles). Undefined: back-to-back bytes, out_valid stays high within a frame.
//  Frame content, field order and counters are identical either way.
// STRUCTURE
//  Shared package (cmd_enc.vh): state encodings, field-presence mask bits (F_BLOCK,F_REG,F_DATA,F_INSTR,F_DELAY),
//    field byte counts; opcode values stay in controller.vh.
//  Sub-module cmd_field_map: combinational opcode -> field mask + unknown flag; reused by the test host model.
// TESTING
//  WRITE_BLOCK_REG blk=0x05 reg=1 data=0xABCD, next every cycle -> bytes op,05,01,AB,CD; frames_sent=1; cmd_ready back after CD.
//  ALLOC_DELAY data=0x1234 delay=0xDEADBEEF -> op,12,34,DE,AD,BE,EF; 7 bytes, no block/reg bytes.
//  SWAP_PIPELINES -> single opcode byte; busy high exactly until its next; back-to-back second command starts the following cycle.
//  Opcode 0xFF -> cmd_error pulse at N+1, out_valid never high, frames_sent unchanged.
//  WRITE_BLOCK_INSTR with next stalled 5 cycles mid-instr -> out_byte stable through stall, no byte skipped or repeated.
//  Reset asserted after 2nd data byte -> all outputs at reset values immediately; next command frames from opcode; gap variant checks 1-cycle bubbles.

Source files
------------

// File: rtl/command_encoder_pkg.sv
// Shared definitions for command_encoder: controller opcodes, core field widths,
// frame-walk states, field-presence mask bits and the field-ordering helper.
package command_encoder_pkg;

    // Field widths mirror the core's block instruction and register address sizes.
    localparam int unsigned BLOCK_INSTR_WIDTH    = 32;
    localparam int unsigned BLOCK_REG_ADDR_WIDTH = 4;
    localparam int unsigned INSTR_BYTES          = BLOCK_INSTR_WIDTH / 8;

    localparam logic [7:0] COMMAND_WRITE_BLOCK_INSTR  = 8'h01;
    localparam logic [7:0] COMMAND_WRITE_BLOCK_REG    = 8'h02;
    localparam logic [7:0] COMMAND_UPDATE_BLOCK_REG   = 8'h03;
    localparam logic [7:0] COMMAND_ALLOC_DELAY        = 8'h04;
    localparam logic [7:0] COMMAND_SET_INPUT_GAIN     = 8'h05;
    localparam logic [7:0] COMMAND_SET_OUTPUT_GAIN    = 8'h06;
    localparam logic [7:0] COMMAND_COMMIT_REG_UPDATES = 8'h07;
    localparam logic [7:0] COMMAND_SWAP_PIPELINES     = 8'h08;
    localparam logic [7:0] COMMAND_RESET_PIPELINE     = 8'h09;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_BLOCK,
        ST_REG,
        ST_DATA,
        ST_INSTR,
        ST_DELAY
    } cmd_state_t;

    localparam int unsigned F_BLOCK    = 0;
    localparam int unsigned F_REG      = 1;
    localparam int unsigned F_DATA     = 2;
    localparam int unsigned F_INSTR    = 3;
    localparam int unsigned F_DELAY    = 4;
    localparam int unsigned NUM_FIELDS = 5;

    typedef logic [NUM_FIELDS-1:0] field_mask_t;

    // First present field strictly after cur in frame order; ST_IDLE ends the frame.
    function automatic cmd_state_t next_field(input cmd_state_t cur, input field_mask_t mask);
        field_mask_t later;
        field_mask_t rem;
        cmd_state_t  nxt;
        case (cur)
            ST_OPCODE: later = 5'b11111;
            ST_BLOCK:  later = 5'b11110;
            ST_REG:    later = 5'b11100;
            ST_DATA:   later = 5'b11000;
            ST_INSTR:  later = 5'b10000;
            default:   later = '0;
        endcase
        rem = mask & later;
        if (rem[F_BLOCK])      nxt = ST_BLOCK;
        else if (rem[F_REG])   nxt = ST_REG;
        else if (rem[F_DATA])  nxt = ST_DATA;
        else if (rem[F_INSTR]) nxt = ST_INSTR;
        else if (rem[F_DELAY]) nxt = ST_DELAY;
        else                   nxt = ST_IDLE;
        return nxt;
    endfunction

endpackage

// File: rtl/command_encoder_field_map.sv
// Combinational opcode decode: which operand fields follow the opcode byte,
// and whether the opcode is unknown to control_unit.
module command_encoder_field_map
    import command_encoder_pkg::*;
(
    input  logic [7:0]  opcode,
    output field_mask_t mask,
    output logic        unknown
);

    always_comb begin
        mask    = '0;
        unknown = 1'b0;
        case (opcode)
            COMMAND_WRITE_BLOCK_INSTR: begin
                mask[F_BLOCK] = 1'b1;
                mask[F_INSTR] = 1'b1;
            end
            COMMAND_WRITE_BLOCK_REG,
            COMMAND_UPDATE_BLOCK_REG: begin
                mask[F_BLOCK] = 1'b1;
                mask[F_REG]   = 1'b1;
                mask[F_DATA]  = 1'b1;
            end
            COMMAND_ALLOC_DELAY: begin
                mask[F_DATA]  = 1'b1;
                mask[F_DELAY] = 1'b1;
            end
            COMMAND_SET_INPUT_GAIN,
            COMMAND_SET_OUTPUT_GAIN: begin
                mask[F_DATA] = 1'b1;
            end
            COMMAND_COMMIT_REG_UPDATES,
            COMMAND_SWAP_PIPELINES,
            COMMAND_RESET_PIPELINE: begin
                mask = '0;
            end
            default: unknown = 1'b1;
        endcase
    end

endmodule

// File: rtl/command_encoder.sv
// Frames engine commands into control_unit's byte stream (opcode, then fields MSB-first).
// Define CMD_ENC_BYTE_GAP_EN to insert a one-cycle out_valid bubble after every accepted byte.
module command_encoder
    import command_encoder_pkg::*;
#(
    parameter int unsigned n_blocks   = 256,
    parameter int unsigned data_width = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [7:0]                      cmd_opcode,
    input  logic [$clog2(n_blocks)-1:0]     cmd_block,
    input  logic [BLOCK_REG_ADDR_WIDTH-1:0] cmd_reg,
    input  logic [data_width-1:0]           cmd_data,
    input  logic [BLOCK_INSTR_WIDTH-1:0]    cmd_instr,
    input  logic [2*data_width-1:0]         cmd_delay,
    output logic [7:0]                      out_byte,
    output logic                            out_valid,
    input  logic                            next,
    output logic                            cmd_error,
    output logic                            busy,
    output logic [15:0]                     frames_sent
);

    localparam int unsigned DATA_BYTES  = data_width / 8;
    localparam int unsigned DELAY_BYTES = (2 * data_width) / 8;

    cmd_state_t state, state_nx, follow_st;

    field_mask_t map_mask, mask_r;
    logic        map_unknown;

    logic [7:0]                   opcode_r;
    logic [7:0]                   block_byte_r;
    logic [7:0]                   reg_byte_r;
    logic [data_width-1:0]        data_sh;
    logic [BLOCK_INSTR_WIDTH-1:0] instr_sh;
    logic [2*data_width-1:0]      delay_sh;
    logic [7:0]                   byte_ctr;
    logic [7:0]                   field_bytes;

    logic accept, advance, field_last, frame_done, gap;

    command_encoder_field_map u_field_map (
        .opcode  (cmd_opcode),
        .mask    (map_mask),
        .unknown (map_unknown)
    );

    assign accept     = cmd_valid && cmd_ready;
    assign advance    = out_valid && next;
    assign field_last = (byte_ctr == field_bytes - 8'd1);
    assign follow_st  = next_field(state, mask_r);
    assign frame_done = advance && field_last && (follow_st == ST_IDLE);

`ifdef CMD_ENC_BYTE_GAP_EN
    logic gap_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) gap_r <= 1'b0;
        else       gap_r <= advance && !frame_done;
    end

    assign gap = gap_r;
`else
    assign gap = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == ST_IDLE) begin
            if (accept && !map_unknown) state_nx = ST_OPCODE;
        end else if (advance && field_last) begin
            state_nx = follow_st;
        end
    end

    always_comb begin
        cmd_ready = (state == ST_IDLE);
        busy      = (state != ST_IDLE);
        out_valid = busy && !gap;
        case (state)
            ST_OPCODE: out_byte = opcode_r;
            ST_BLOCK:  out_byte = block_byte_r;
            ST_REG:    out_byte = reg_byte_r;
            ST_DATA:   out_byte = data_sh[data_width-1 -: 8];
            ST_INSTR:  out_byte = instr_sh[BLOCK_INSTR_WIDTH-1 -: 8];
            ST_DELAY:  out_byte = delay_sh[2*data_width-1 -: 8];
            default:   out_byte = 8'h00;
        endcase
    end

    always_comb begin
        case (state)
            ST_DATA:  field_bytes = 8'(DATA_BYTES);
            ST_INSTR: field_bytes = 8'(INSTR_BYTES);
            ST_DELAY: field_bytes = 8'(DELAY_BYTES);
            default:  field_bytes = 8'd1;
        endcase
    end

    // Multi-byte fields are shifted left on each accepted byte so the MSB is always on top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_r       <= '0;
            opcode_r     <= '0;
            block_byte_r <= '0;
            reg_byte_r   <= '0;
            data_sh      <= '0;
            instr_sh     <= '0;
            delay_sh     <= '0;
            byte_ctr     <= '0;
            cmd_error    <= 1'b0;
            frames_sent  <= '0;
        end else begin
            cmd_error <= accept && map_unknown;
            if (accept) begin
                mask_r       <= map_mask;
                opcode_r     <= cmd_opcode;
                block_byte_r <= 8'(cmd_block);
                reg_byte_r   <= 8'(cmd_reg);
                data_sh      <= cmd_data;
                instr_sh     <= cmd_instr;
                delay_sh     <= cmd_delay;
                byte_ctr     <= '0;
            end else if (advance) begin
                if (field_last) byte_ctr <= '0;
                else            byte_ctr <= byte_ctr + 8'd1;
                case (state)
                    ST_DATA:  data_sh  <= data_sh << 8;
                    ST_INSTR: instr_sh <= instr_sh << 8;
                    ST_DELAY: delay_sh <= delay_sh << 8;
                    default:  ;
                endcase
            end
            if (frame_done) frames_sent <= frames_sent + 16'd1;
        end
    end

endmodule

// File: tb/tb_command_encoder.sv
// Scoreboard bench for command_encoder: directed frames push expected bytes, a monitor
// pops them on every out_valid&&next handshake and checks stream invariants each cycle.
`timescale 1ns/1ps
module tb_command_encoder;
    import command_encoder_pkg::*;

`ifdef CMD_ENC_BYTE_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [7:0]  cmd_block;
    logic [3:0]  cmd_reg;
    logic [15:0] cmd_data;
    logic [31:0] cmd_instr;
    logic [31:0] cmd_delay;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        next;
    logic        cmd_error;
    logic        busy;
    logic [15:0] frames_sent;

    int          total    = 0;
    int          passed   = 0;
    int          hs_count = 0;
    bit          next_en  = 1'b1;
    logic [7:0]  exp_q[$];

    bit          mon_prev_hs    = 1'b0;
    bit          mon_prev_stall = 1'b0;
    logic [7:0]  mon_prev_byte  = 8'h00;

    always #5 clk = ~clk;

    command_encoder #(.n_blocks(256), .data_width(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_block   (cmd_block),
        .cmd_reg     (cmd_reg),
        .cmd_data    (cmd_data),
        .cmd_instr   (cmd_instr),
        .cmd_delay   (cmd_delay),
        .out_byte    (out_byte),
        .out_valid   (out_valid),
        .next        (next),
        .cmd_error   (cmd_error),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Consumer: next follows next_en, updated just after each rising edge.
    initial begin
        next = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            next = next_en;
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                mon_prev_hs    = 1'b0;
                mon_prev_stall = 1'b0;
            end else begin
                check("valid_shape", out_valid, busy ? (GAP ? !mon_prev_hs : 1'b1) : 1'b0);
                check("ready_vs_busy", cmd_ready, !busy);
                if (mon_prev_stall && out_valid) check("stall_stable", out_byte, mon_prev_byte);
                if (out_valid && next) begin
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected no byte", out_byte);
                    end else begin
                        check("stream_byte", out_byte, exp_q.pop_front());
                    end
                end
                mon_prev_hs    = out_valid && next;
                mon_prev_stall = out_valid && !next;
                mon_prev_byte  = out_byte;
            end
        end
    end

    task automatic issue(input logic [7:0] op, input logic [7:0] blk, input logic [3:0] rg,
                         input logic [15:0] dat, input logic [31:0] ins, input logic [31:0] dly,
                         output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!cmd_ready && waited < 200);
        if (!cmd_ready) begin
            total++;
            $display("FAIL accept_timeout: cmd_ready 0 after %0d cycles, expected 1", waited);
            return;
        end
        cmd_opcode = op;
        cmd_block  = blk;
        cmd_reg    = rg;
        cmd_data   = dat;
        cmd_instr  = ins;
        cmd_delay  = dly;
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic check_opcode_cycle(input logic [7:0] op);
        check("n1_out_valid", out_valid, 1'b1);
        check("n1_out_byte", out_byte, op);
        check("n1_busy", busy, 1'b1);
        check("n1_cmd_ready", cmd_ready, 1'b0);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_busy", busy, 1'b0);
        check("drain_pending", exp_q.size(), 0);
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        while (hs_count < target && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("hs_reached", hs_count, target);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int w;
        int base;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_block  = '0;
        cmd_reg    = '0;
        cmd_data   = '0;
        cmd_instr  = '0;
        cmd_delay  = '0;
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_byte", out_byte, 8'h00);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_cmd_error", cmd_error, 1'b0);
        check("rst_frames", frames_sent, 16'd0);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;

        // WRITE_BLOCK_REG blk=05 reg=1 data=ABCD
        exp_q.push_back(8'h02); exp_q.push_back(8'h05); exp_q.push_back(8'h01);
        exp_q.push_back(8'hAB); exp_q.push_back(8'hCD);
        issue(COMMAND_WRITE_BLOCK_REG, 8'h05, 4'h1, 16'hABCD, 32'h0, 32'h0, w);
        check_opcode_cycle(8'h02);
        wait_done();
        check("frames_wbr", frames_sent, 16'd1);
        check("ready_after_wbr", cmd_ready, 1'b1);

        // ALLOC_DELAY, with a competing cmd_valid held off while busy
        exp_q.push_back(8'h04); exp_q.push_back(8'h12); exp_q.push_back(8'h34);
        exp_q.push_back(8'hDE); exp_q.push_back(8'hAD); exp_q.push_back(8'hBE);
        exp_q.push_back(8'hEF);
        issue(COMMAND_ALLOC_DELAY, 8'h77, 4'h3, 16'h1234, 32'h0, 32'hDEADBEEF, w);
        check_opcode_cycle(8'h04);
        cmd_opcode = 8'hFF;
        cmd_valid  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("holdoff_no_error", cmd_error, 1'b0);
        end
        cmd_valid = 1'b0;
        wait_done();
        check("frames_alloc", frames_sent, 16'd2);

        // SWAP_PIPELINES then RESET_PIPELINE back-to-back
        exp_q.push_back(8'h08);
        issue(COMMAND_SWAP_PIPELINES, 8'h00, 4'h0, 16'h0, 32'h0, 32'h0, w);
        check_opcode_cycle(8'h08);
        exp_q.push_back(8'h09);
        issue(COMMAND_RESET_PIPELINE, 8'h00, 4'h0, 16'h0, 32'h0, 32'h0, w);
        check("b2b_wait_cycles", w, 2);
        check("frames_after_swap", frames_sent, 16'd3);
        check_opcode_cycle(8'h09);
        wait_done();
        check("frames_b2b", frames_sent, 16'd4);

        // Unknown opcode 0xFF
        issue(8'hFF, 8'h00, 4'h0, 16'h0, 32'h0, 32'h0, w);
        check("unk_error_n1", cmd_error, 1'b1);
        check("unk_valid_n1", out_valid, 1'b0);
        check("unk_busy_n1", busy, 1'b0);
        check("unk_ready_n1", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        check("unk_error_pulse", cmd_error, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("unk_frames", frames_sent, 16'd4);

        // WRITE_BLOCK_INSTR with a 5-cycle consumer stall on the second instr byte
        exp_q.push_back(8'h01); exp_q.push_back(8'h3C); exp_q.push_back(8'h11);
        exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        base = hs_count;
        issue(COMMAND_WRITE_BLOCK_INSTR, 8'h3C, 4'h0, 16'h0, 32'h11223344, 32'h0, w);
        check_opcode_cycle(8'h01);
        wait_hs(base + 3);
        next_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("stall_valid", out_valid, 1'b1);
        check("stall_byte", out_byte, 8'h22);
        @(negedge clk);
        #1;
        next_en = 1'b1;
        wait_done();
        check("frames_wbi", frames_sent, 16'd5);

        // Reset in the middle of an ALLOC_DELAY frame, then a fresh frame
        exp_q.push_back(8'h04); exp_q.push_back(8'h0A); exp_q.push_back(8'h0B);
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        exp_q.push_back(8'h04);
        base = hs_count;
        issue(COMMAND_ALLOC_DELAY, 8'h00, 4'h0, 16'h0A0B, 32'h0, 32'h01020304, w);
        wait_hs(base + 3);
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_byte", out_byte, 8'h00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_cmd_ready", cmd_ready, 1'b1);
        check("mid_rst_cmd_error", cmd_error, 1'b0);
        check("mid_rst_frames", frames_sent, 16'd0);
        @(negedge clk);
        #2;
        reset = 1'b0;

        exp_q.push_back(8'h05); exp_q.push_back(8'h98); exp_q.push_back(8'h76);
        issue(COMMAND_SET_INPUT_GAIN, 8'h00, 4'h0, 16'h9876, 32'h0, 32'h0, w);
        check_opcode_cycle(8'h05);
        wait_done();
        check("frames_after_rst", frames_sent, 16'd1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
